// File: rtl/uram_tdp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : uram_tdp_pipe
// Purpose  : Parametrised true dual-port RAM (ultraRAM target) for operand and
//            result stores. It has per-byte write enables, a configurable read
//            pipeline with valid tracking, and same-address collision
//            detection with sticky status flags.
// Ports    : CLK, RESET          clock, synchronous active-high reset
//            wrenX/wrbeX         write request / byte enables (X = A, B)
//            wraddrsX/wrdataX    write address / data
//            rdenX/rdaddrsX      read request / address
//            rddataX/rdvalidX    read data / one-cycle valid pulse
//            collision           one-cycle pulse on a cross-port conflict
//            status[3:0]         sticky: A drop, B drop, W-W, R-W
//            clr_status          clears status on the next edge
// Revision : 1.0 - initial release
// ============================================================================
module uram_tdp_pipe #(
  parameter int ADDRS_WIDTH = 12,
  parameter int DWIDTH      = 64,
  parameter int NBPIPE      = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   wrenA,
  input  logic [DWIDTH/8-1:0]    wrbeA,
  input  logic [ADDRS_WIDTH-1:0] wraddrsA,
  input  logic [DWIDTH-1:0]      wrdataA,
  input  logic                   rdenA,
  input  logic [ADDRS_WIDTH-1:0] rdaddrsA,
  output logic [DWIDTH-1:0]      rddataA,
  output logic                   rdvalidA,
  input  logic                   wrenB,
  input  logic [DWIDTH/8-1:0]    wrbeB,
  input  logic [ADDRS_WIDTH-1:0] wraddrsB,
  input  logic [DWIDTH-1:0]      wrdataB,
  input  logic                   rdenB,
  input  logic [ADDRS_WIDTH-1:0] rdaddrsB,
  output logic [DWIDTH-1:0]      rddataB,
  output logic                   rdvalidB,
  output logic                   collision,
  output logic [3:0]             status,
  input  logic                   clr_status
);

  localparam int c_NB    = DWIDTH / 8;
  localparam int c_DEPTH = 1 << ADDRS_WIDTH;

  if (NBPIPE < 0 || NBPIPE > 4) begin : g_bad_nbpipe
    $error("uram_tdp_pipe: NBPIPE=%0d outside 0..4", NBPIPE);
  end
  if (DWIDTH % 8 != 0) begin : g_bad_dwidth
    $error("uram_tdp_pipe: DWIDTH=%0d is not a multiple of 8", DWIDTH);
  end

  logic [DWIDTH-1:0] r_mem [c_DEPTH];

  // A simultaneous write on the same port takes priority over its read.
  logic w_rdaccA, w_rdaccB, w_dropA, w_dropB, w_ww, w_rw;
  assign w_rdaccA = rdenA & ~wrenA;
  assign w_rdaccB = rdenB & ~wrenB;
  assign w_dropA  = rdenA &  wrenA;
  assign w_dropB  = rdenB &  wrenB;
  assign w_ww     = wrenA & wrenB & (wraddrsA == wraddrsB);
  assign w_rw     = (w_rdaccA & wrenB & (rdaddrsA == wraddrsB))
                  | (w_rdaccB & wrenA & (rdaddrsB == wraddrsA));

  // Port B bytes are assigned first so that on a same-address collision the
  // later port-A assignment overrides every byte that A enables.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < c_NB; k++) begin
      if (wrenB && wrbeB[k]) r_mem[wraddrsB][8*k +: 8] <= wrdataB[8*k +: 8];
      if (wrenA && wrbeA[k]) r_mem[wraddrsA][8*k +: 8] <= wrdataA[8*k +: 8];
    end
  end

  // Stage 0 samples the array (old contents on a read-write collision, since
  // the write lands on the same edge). Stages 1..NBPIPE only load when the
  // valid bit arriving from the previous stage is set, so the last stage
  // holds its data between pulses.
  logic [NBPIPE:0]   r_pvA, r_pvB;
  logic [DWIDTH-1:0] r_pdA [NBPIPE+1];
  logic [DWIDTH-1:0] r_pdB [NBPIPE+1];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pvA <= '0;
      for (int s = 0; s <= NBPIPE; s++) r_pdA[s] <= '0;
    end else begin
      r_pvA[0] <= w_rdaccA;
      if (w_rdaccA) r_pdA[0] <= r_mem[rdaddrsA];
      for (int s = 1; s <= NBPIPE; s++) begin
        r_pvA[s] <= r_pvA[s-1];
        if (r_pvA[s-1]) r_pdA[s] <= r_pdA[s-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pvB <= '0;
      for (int s = 0; s <= NBPIPE; s++) r_pdB[s] <= '0;
    end else begin
      r_pvB[0] <= w_rdaccB;
      if (w_rdaccB) r_pdB[0] <= r_mem[rdaddrsB];
      for (int s = 1; s <= NBPIPE; s++) begin
        r_pvB[s] <= r_pvB[s-1];
        if (r_pvB[s-1]) r_pdB[s] <= r_pdB[s-1];
      end
    end
  end

  // A new event in the same cycle as clr_status survives the clear.
  logic       r_coll;
  logic [3:0] r_status;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_coll   <= 1'b0;
      r_status <= '0;
    end else begin
      r_coll   <= w_ww | w_rw;
      r_status <= (clr_status ? 4'b0000 : r_status)
                | {w_rw, w_ww, w_dropB, w_dropA};
    end
  end

  assign rddataA   = r_pdA[NBPIPE];
  assign rdvalidA  = r_pvA[NBPIPE];
  assign rddataB   = r_pdB[NBPIPE];
  assign rdvalidB  = r_pvB[NBPIPE];
  assign collision = r_coll;
  assign status    = r_status;

endmodule
`default_nettype wire

// File: tb/tb_uram_tdp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_uram_tdp_pipe
// Purpose  : Directed self-checking bench for uram_tdp_pipe (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uram_tdp_pipe;

  logic        CLK, RESET;
  logic        wrenA, wrenB, rdenA, rdenB, rdvalidA, rdvalidB;
  logic        collision, clr_status;
  logic [7:0]  wrbeA, wrbeB;
  logic [11:0] wraddrsA, wraddrsB, rdaddrsA, rdaddrsB;
  logic [63:0] wrdataA, wrdataB, rddataA, rddataB;
  logic [3:0]  status;

  int n_total = 0;
  int n_bad   = 0;

  uram_tdp_pipe dut (
    .CLK(CLK), .RESET(RESET),
    .wrenA(wrenA), .wrbeA(wrbeA), .wraddrsA(wraddrsA), .wrdataA(wrdataA),
    .rdenA(rdenA), .rdaddrsA(rdaddrsA), .rddataA(rddataA), .rdvalidA(rdvalidA),
    .wrenB(wrenB), .wrbeB(wrbeB), .wraddrsB(wraddrsB), .wrdataB(wrdataB),
    .rdenB(rdenB), .rdaddrsB(rdaddrsB), .rddataB(rddataB), .rdvalidB(rdvalidB),
    .collision(collision), .status(status), .clr_status(clr_status)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Inputs are driven at a negedge; each task returns at a later negedge.
  task automatic wr(input bit pb, input logic [11:0] a, input logic [63:0] d, input logic [7:0] be);
    if (pb) begin wrenB = 1; wraddrsB = a; wrdataB = d; wrbeB = be; end
    else    begin wrenA = 1; wraddrsA = a; wrdataA = d; wrbeA = be; end
    @(negedge CLK);
    wrenA = 0; wrenB = 0;
  endtask

  task automatic rd(input bit pb, input logic [11:0] a, input logic [63:0] exp, input string tag);
    int lat;
    if (pb) begin rdenB = 1; rdaddrsB = a; end
    else    begin rdenA = 1; rdaddrsA = a; end
    @(negedge CLK);
    rdenA = 0; rdenB = 0;
    lat = 1;
    while (!(pb ? rdvalidB : rdvalidA) && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check({tag, "_data"}, pb ? rddataB : rddataA, exp);
    @(negedge CLK);
    check({tag, "_pulse"}, {63'b0, pb ? rdvalidB : rdvalidA}, 64'd0);
  endtask

  task automatic clr();
    clr_status = 1;
    @(negedge CLK);
    clr_status = 0;
    check("clr_status", {60'b0, status}, 64'd0);
  endtask

  initial begin
    int lat, nv;
    RESET = 1; clr_status = 0;
    wrenA = 0; wrenB = 0; rdenA = 0; rdenB = 0;
    wrbeA = 0; wrbeB = 0; wraddrsA = 0; wraddrsB = 0;
    wrdataA = 0; wrdataB = 0; rdaddrsA = 0; rdaddrsB = 0;
    repeat (3) @(negedge CLK);
    RESET = 0;
    check("rst_rddataA", rddataA, 64'd0);
    check("rst_rddataB", rddataB, 64'd0);
    check("rst_valid", {62'b0, rdvalidA, rdvalidB}, 64'd0);
    check("rst_coll", {63'b0, collision}, 64'd0);
    check("rst_status", {60'b0, status}, 64'd0);

    // 1: basic write A, read B
    wr(0, 12'h010, 64'h0123456789ABCDEF, 8'hFF);
    @(negedge CLK);
    rd(1, 12'h010, 64'h0123456789ABCDEF, "t1");

    // 2: byte enables
    wr(0, 12'h020, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    wr(0, 12'h020, 64'h0000000000000000, 8'h0F);
    rd(0, 12'h020, 64'hFFFFFFFF00000000, "t2");
    check("t2_status", {60'b0, status}, 64'd0);

    // 3: write-write collision
    wrenA = 1; wraddrsA = 12'h030; wrdataA = 64'hAAAAAAAAAAAAAAAA; wrbeA = 8'hF0;
    wrenB = 1; wraddrsB = 12'h030; wrdataB = 64'h5555555555555555; wrbeB = 8'hFF;
    @(negedge CLK);
    wrenA = 0; wrenB = 0;
    check("t3_coll", {63'b0, collision}, 64'd1);
    check("t3_status", {60'b0, status}, 64'h4);
    @(negedge CLK);
    check("t3_coll_once", {63'b0, collision}, 64'd0);
    rd(1, 12'h030, 64'hAAAAAAAA55555555, "t3");

    // 4: read-write collision returns old data
    clr();
    wr(1, 12'h040, 64'h11, 8'hFF);
    rdenB = 1; rdaddrsB = 12'h040;
    wrenA = 1; wraddrsA = 12'h040; wrdataA = 64'h22; wrbeA = 8'hFF;
    @(negedge CLK);
    rdenB = 0; wrenA = 0;
    check("t4_coll", {63'b0, collision}, 64'd1);
    check("t4_status", {60'b0, status}, 64'h8);
    lat = 1;
    while (!rdvalidB && lat < 10) begin @(negedge CLK); lat++; end
    check("t4_lat", 64'(lat), 64'd3);
    check("t4_old", rddataB, 64'h11);
    @(negedge CLK);
    rd(1, 12'h040, 64'h22, "t4_new");

    // 5: dropped read, then clear
    clr();
    wrenA = 1; wraddrsA = 12'h050; wrdataA = 64'h77; wrbeA = 8'hFF;
    rdenA = 1; rdaddrsA = 12'h010;
    @(negedge CLK);
    wrenA = 0; rdenA = 0;
    check("t5_status", {60'b0, status}, 64'h1);
    check("t5_coll", {63'b0, collision}, 64'd0);
    nv = 0;
    for (int j = 0; j < 5; j++) begin
      if (rdvalidA) nv++;
      @(negedge CLK);
    end
    check("t5_no_valid", 64'(nv), 64'd0);
    clr();

    // 6: back-to-back reads, then reset with reads in flight
    for (int i = 0; i < 8; i++) wr(1, 12'h100 + 12'(i), 64'hC0DE000000000000 | 64'(i), 8'hFF);
    nv = 0;
    for (int j = 0; j < 14; j++) begin
      if (j < 8) begin rdenA = 1; rdaddrsA = 12'h100 + 12'(j); end
      else rdenA = 0;
      check("t6_valid", {63'b0, rdvalidA}, (j >= 3 && j < 11) ? 64'd1 : 64'd0);
      if (rdvalidA) begin
        nv++;
        check("t6_data", rddataA, 64'hC0DE000000000000 | 64'(j - 3));
      end
      @(negedge CLK);
    end
    check("t6_count", 64'(nv), 64'd8);

    rdenA = 1; rdaddrsA = 12'h101;
    @(negedge CLK);
    rdaddrsA = 12'h102;
    @(negedge CLK);
    rdenA = 0; RESET = 1;
    @(negedge CLK);
    RESET = 0;
    check("t6_rst_data", rddataA, 64'd0);
    check("t6_rst_status", {60'b0, status}, 64'd0);
    nv = 0;
    for (int j = 0; j < 4; j++) begin
      if (rdvalidA) nv++;
      @(negedge CLK);
    end
    check("t6_rst_no_valid", 64'(nv), 64'd0);
    rd(0, 12'h101, 64'hC0DE000000000001, "t6_retain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
